pipe_scoreboard: RTL and testbench

- Parametrised hazard and forwarding unit for the in-order pipeline. It replaces the fixed three-stage ex/mem/wb destination compare done in decode.
- Tracks the destination registers of in-flight instructions across DEPTH post-decode stages.
- Each cycle it decides, per decode-stage source operand, one of three outcomes: read the register file, forward from a stage, or stall.
- Supports a stall-only mode, load-use latency, decode flush, and a saturating stall counter.

---
 rtl/pipe_scoreboard.sv | 110 +++++++++++
 tb/tb_pipe_scoreboard.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_scoreboard.sv
// Hazard/forwarding scoreboard: tracks destinations of in-flight instructions over
// DEPTH post-decode slots and picks register file, forward, or stall per source.
module pipe_scoreboard #(
    parameter int unsigned REG_W      = 3,
    parameter int unsigned DEPTH      = 3,
    parameter bit          FWD_EN     = 1'b1,
    parameter int unsigned LOAD_STAGE = 1,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             issue_valid,
    input  logic             issue_we,
    input  logic [REG_W-1:0] issue_dest,
    input  logic             issue_is_load,
    input  logic [REG_W-1:0] src_a,
    input  logic             src_a_used,
    input  logic [REG_W-1:0] src_b,
    input  logic             src_b_used,
    input  logic             flush,
    output logic             stall,
    output logic [DEPTH-1:0] fwd_a,
    output logic [DEPTH-1:0] fwd_b,
    output logic [3:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt
);

    logic [DEPTH-1:0]            v_q, v_d;
    logic [DEPTH-1:0]            we_q, we_d;
    logic [DEPTH-1:0]            ld_q, ld_d;
    logic [DEPTH-1:0][REG_W-1:0] dest_q, dest_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic                        haz_a, haz_b;

    // Returns {hazard, one-hot forward select}; only the youngest matching slot counts.
    function automatic logic [DEPTH:0] resolve(
        input logic                        used,
        input logic [REG_W-1:0]            src,
        input logic [DEPTH-1:0]            v,
        input logic [DEPTH-1:0]            we,
        input logic [DEPTH-1:0]            ld,
        input logic [DEPTH-1:0][REG_W-1:0] dest
    );
        logic [DEPTH:0] r;
        logic           found;
        r     = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (!found && used && v[i] && we[i] && (dest[i] == src)) begin
                found = 1'b1;
                if (!FWD_EN || (ld[i] && (i < LOAD_STAGE))) begin
                    r[DEPTH] = 1'b1;
                end else begin
                    r[i] = 1'b1;
                end
            end
        end
        return r;
    endfunction

    always_comb begin
        {haz_a, fwd_a} = resolve(src_a_used, src_a, v_q, we_q, ld_q, dest_q);
        {haz_b, fwd_b} = resolve(src_b_used, src_b, v_q, we_q, ld_q, dest_q);
        stall          = issue_valid & ~flush & (haz_a | haz_b);
    end

    always_comb begin
        v_d       = '0;
        we_d      = '0;
        ld_d      = '0;
        dest_d    = '0;
        v_d[0]    = issue_valid & ~stall & ~flush;
        we_d[0]   = v_d[0] & issue_we;
        ld_d[0]   = v_d[0] & issue_is_load;
        dest_d[0] = v_d[0] ? issue_dest : '0;
        for (int unsigned i = 1; i < DEPTH; i++) begin
            v_d[i]    = v_q[i-1];
            we_d[i]   = we_q[i-1];
            ld_d[i]   = ld_q[i-1];
            dest_d[i] = dest_q[i-1];
        end
        cnt_d = (stall && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;
    end

    always_comb begin
        occupancy = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            occupancy = occupancy + {3'b000, v_q[i] & we_q[i]};
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            v_q    <= '0;
            we_q   <= '0;
            ld_q   <= '0;
            dest_q <= '0;
            cnt_q  <= '0;
        end else begin
            v_q    <= v_d;
            we_q   <= we_d;
            ld_q   <= ld_d;
            dest_q <= dest_d;
            cnt_q  <= cnt_d;
        end
    end

    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_scoreboard.sv
// Scoreboard bench: three parameterisations share one stimulus stream; a queue-based
// model of in-flight instructions predicts each cycle's outputs for every instance.
module tb_pipe_scoreboard;

    localparam int NI = 3;

    logic       clock = 1'b0;
    logic       resetn;
    logic       issue_valid, issue_we, issue_is_load, src_a_used, src_b_used, flush;
    logic [2:0] issue_dest, src_a, src_b;

    logic        s0, s1, s2;
    logic [2:0]  fa0, fb0, fa1, fb1;
    logic [4:0]  fa2, fb2;
    logic [3:0]  o0, o1, o2;
    logic [15:0] c0, c1;
    logic [1:0]  c2;

    always #5 clock = ~clock;

    pipe_scoreboard #(.REG_W(3), .DEPTH(3), .FWD_EN(1'b1), .LOAD_STAGE(1), .CNT_W(16)) u_fwd (
        .clock(clock), .resetn(resetn), .issue_valid(issue_valid), .issue_we(issue_we),
        .issue_dest(issue_dest), .issue_is_load(issue_is_load), .src_a(src_a),
        .src_a_used(src_a_used), .src_b(src_b), .src_b_used(src_b_used), .flush(flush),
        .stall(s0), .fwd_a(fa0), .fwd_b(fb0), .occupancy(o0), .stall_cnt(c0));

    pipe_scoreboard #(.REG_W(3), .DEPTH(3), .FWD_EN(1'b0), .LOAD_STAGE(1), .CNT_W(16)) u_nofwd (
        .clock(clock), .resetn(resetn), .issue_valid(issue_valid), .issue_we(issue_we),
        .issue_dest(issue_dest), .issue_is_load(issue_is_load), .src_a(src_a),
        .src_a_used(src_a_used), .src_b(src_b), .src_b_used(src_b_used), .flush(flush),
        .stall(s1), .fwd_a(fa1), .fwd_b(fb1), .occupancy(o1), .stall_cnt(c1));

    pipe_scoreboard #(.REG_W(3), .DEPTH(5), .FWD_EN(1'b1), .LOAD_STAGE(3), .CNT_W(2)) u_deep (
        .clock(clock), .resetn(resetn), .issue_valid(issue_valid), .issue_we(issue_we),
        .issue_dest(issue_dest), .issue_is_load(issue_is_load), .src_a(src_a),
        .src_a_used(src_a_used), .src_b(src_b), .src_b_used(src_b_used), .flush(flush),
        .stall(s2), .fwd_a(fa2), .fwd_b(fb2), .occupancy(o2), .stall_cnt(c2));

    int m_depth[NI] = '{3, 3, 5};
    int m_ls[NI]    = '{1, 1, 3};
    int m_fwd[NI]   = '{1, 0, 1};
    int m_cmax[NI]  = '{65535, 65535, 3};

    // Model: per instance, a queue of in-flight instructions indexed by age (0 = youngest).
    typedef struct {
        bit v;
        bit we;
        bit ld;
        int dest;
    } slot_t;
    typedef slot_t slotq_t[$];
    slotq_t mq[NI];
    int     mcnt[NI];

    typedef struct {
        int k;
        int st;
        int fa;
        int fb;
        int oc;
        int cn;
    } exp_t;
    exp_t expq[$];

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input int k, input int act, input int expv);
        n_total++;
        if (act == expv) n_pass++;
        else $display("FAIL %s dut=%0d actual=%0d required=%0d", name, k, act, expv);
    endtask

    function automatic void resolve(input int k, input bit used, input int src,
                                    output bit hz, output int fwd);
        hz  = 0;
        fwd = 0;
        if (!used) return;
        for (int i = 0; i < mq[k].size(); i++) begin
            if (mq[k][i].v && mq[k][i].we && mq[k][i].dest == src) begin
                if (m_fwd[k] == 0 || (mq[k][i].ld && i < m_ls[k])) hz = 1;
                else fwd = 1 << i;
                return;
            end
        end
    endfunction

    function automatic bit exp_stall(input int k);
        bit ha, hb;
        int fa, fb;
        resolve(k, src_a_used, int'(src_a), ha, fa);
        resolve(k, src_b_used, int'(src_b), hb, fb);
        return issue_valid && !flush && (ha || hb);
    endfunction

    task automatic model_edge();
        for (int k = 0; k < NI; k++) begin
            if (!resetn) begin
                mq[k].delete();
                mcnt[k] = 0;
            end else begin
                bit    st;
                slot_t s;
                st     = exp_stall(k);
                s.v    = issue_valid && !st && !flush;
                s.we   = s.v && issue_we;
                s.ld   = s.v && issue_is_load;
                s.dest = s.v ? int'(issue_dest) : 0;
                mq[k].push_front(s);
                if (mq[k].size() > m_depth[k]) void'(mq[k].pop_back());
                if (st && mcnt[k] < m_cmax[k]) mcnt[k]++;
            end
        end
    endtask

    task automatic push_exp();
        for (int k = 0; k < NI; k++) begin
            exp_t e;
            bit   ha, hb;
            e.k = k;
            resolve(k, src_a_used, int'(src_a), ha, e.fa);
            resolve(k, src_b_used, int'(src_b), hb, e.fb);
            e.st = (issue_valid && !flush && (ha || hb)) ? 1 : 0;
            e.oc = 0;
            for (int i = 0; i < mq[k].size(); i++)
                if (mq[k][i].v && mq[k][i].we) e.oc++;
            e.cn = mcnt[k];
            expq.push_back(e);
        end
    endtask

    function automatic void get_act(input int k, output int st, output int fa, output int fb,
                                    output int oc, output int cn);
        case (k)
            0: begin st = int'(s0); fa = int'(fa0); fb = int'(fb0); oc = int'(o0); cn = int'(c0); end
            1: begin st = int'(s1); fa = int'(fa1); fb = int'(fb1); oc = int'(o1); cn = int'(c1); end
            default: begin st = int'(s2); fa = int'(fa2); fb = int'(fb2); oc = int'(o2); cn = int'(c2); end
        endcase
    endfunction

    always @(negedge clock) begin : monitor
        exp_t e;
        int   st, fa, fb, oc, cn;
        while (expq.size() > 0) begin
            e = expq.pop_front();
            get_act(e.k, st, fa, fb, oc, cn);
            chk("stall", e.k, st, e.st);
            chk("fwd_a", e.k, fa, e.fa);
            chk("fwd_b", e.k, fb, e.fb);
            chk("occupancy", e.k, oc, e.oc);
            chk("stall_cnt", e.k, cn, e.cn);
        end
    end

    task automatic cycle(input bit v, input bit we, input int dest, input bit ld,
                         input int sa, input bit ua, input int sb, input bit ub, input bit fl);
        int d, a, b;
        @(posedge clock);
        #1;
        model_edge();
        d = dest; a = sa; b = sb;
        issue_valid   = v;
        issue_we      = we;
        issue_dest    = d[2:0];
        issue_is_load = ld;
        src_a         = a[2:0];
        src_a_used    = ua;
        src_b         = b[2:0];
        src_b_used    = ub;
        flush         = fl;
        push_exp();
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin : driver
        int st, fa, fb, oc, cn;
        resetn = 1'b0;
        issue_valid = 0; issue_we = 0; issue_dest = '0; issue_is_load = 0;
        src_a = '0; src_a_used = 0; src_b = '0; src_b_used = 0; flush = 0;
        idle(2);
        resetn = 1'b1;

        // ALU writer then two dependent reads: forwards from slot 0, then slot 1
        cycle(1, 1, 3, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 3, 1, 0, 0, 0);
        cycle(1, 0, 0, 0, 3, 1, 0, 0, 0);
        idle(5);

        // load-use on source B
        cycle(1, 1, 5, 1, 0, 0, 0, 0, 0);
        repeat (4) cycle(1, 0, 0, 0, 0, 0, 5, 1, 0);
        idle(5);

        // two writers of r4 (slots 0 and 2), then a flushed dependent
        cycle(1, 1, 4, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle(1, 1, 4, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 4, 1, 0, 0, 0);
        cycle(1, 1, 6, 0, 4, 1, 4, 1, 1);
        idle(5);

        // ALU writer of r2 with a long-held dependent; also same-register sources and r0
        cycle(1, 1, 2, 0, 0, 0, 0, 0, 0);
        repeat (6) cycle(1, 0, 0, 0, 2, 1, 2, 1, 0);
        cycle(1, 1, 0, 0, 0, 1, 0, 0, 0);
        cycle(1, 1, 1, 0, 0, 1, 0, 1, 0);
        idle(5);

        // load r1 then dependent: deep instance forwards from slot 3 after three stalls
        cycle(1, 1, 1, 1, 0, 0, 0, 0, 0);
        repeat (5) cycle(1, 0, 0, 0, 1, 1, 0, 0, 0);
        idle(5);

        // asynchronous reset in the middle of a stall, checked with no clock edge
        cycle(1, 1, 7, 1, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 7, 1, 7, 1, 0);
        @(negedge clock);
        #1;
        resetn = 1'b0;
        #1;
        for (int k = 0; k < NI; k++) begin
            get_act(k, st, fa, fb, oc, cn);
            chk("reset_stall", k, st, 0);
            chk("reset_cnt", k, cn, 0);
            chk("reset_occ", k, oc, 0);
            chk("reset_fwd_a", k, fa, 0);
            mq[k].delete();
            mcnt[k] = 0;
        end
        cycle(1, 0, 0, 0, 7, 1, 7, 1, 0);
        resetn = 1'b1;
        cycle(1, 0, 0, 0, 7, 1, 7, 1, 0);

        repeat (2000) begin
            cycle($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 7, $urandom_range(0, 7),
                  $urandom_range(0, 3) == 0, $urandom_range(0, 7), $urandom_range(0, 9) < 8,
                  $urandom_range(0, 7), $urandom_range(0, 9) < 6, $urandom_range(0, 9) == 0);
        end

        @(negedge clock);
        #1;
        chk("drain", 0, expq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
